// File: rtl/intr_pkg.sv
// intr_pkg: shared defaults, FSM state codes and reset constants for the interrupt controller
package intr_pkg;
  localparam int NUM_IRQ_DEFAULT = 4;
  localparam int VEC_W_DEFAULT = 2;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;
  localparam logic [NUM_IRQ_DEFAULT-1:0] MASK_RESET = '0;
endpackage

// File: rtl/intr_prio_sel.sv
// intr_prio_sel: lowest-index-first selector over the eligible interrupt set
module intr_prio_sel #(
  parameter int NUM_IRQ = 4,
  parameter int VEC_W = 2
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [VEC_W-1:0]   vec,
  output logic               any_valid
);
  assign any_valid = |req;
  // scan from the top so the lowest set index is the last one written
  always_comb begin
    vec = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (req[i]) vec = VEC_W'(i);
  end
endmodule

// File: rtl/intr_controller.sv
// intr_controller: edge-latched, masked, fixed-priority interrupt sequencer; define INTR_CTRL_SYNC_EN to add a 2-flop input synchronizer
module intr_controller
  import intr_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
  parameter int VEC_W = VEC_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               cpu_ack,
  input  logic               cpu_eoi,
  output logic               irq_out,
  output logic [VEC_W-1:0]   irq_vec,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service,
  output logic [NUM_IRQ-1:0] mask
);
  if (NUM_IRQ < 2 || (NUM_IRQ & (NUM_IRQ - 1)) != 0 || VEC_W != $clog2(NUM_IRQ)) begin : g_bad_cfg
    $error("intr_controller: NUM_IRQ must be a power of 2 >= 2 and VEC_W = log2(NUM_IRQ)");
  end
  logic [1:0]         state;
  logic [NUM_IRQ-1:0] irq_src, irq_d, rise, elig, cur, clr;
  logic [VEC_W-1:0]   win;
  logic               any, take;
`ifdef INTR_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] sync_q1, sync_q2;
  // two-stage synchronizer for asynchronous interrupt lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end
  assign irq_src = sync_q2;
`else
  assign irq_src = irq_in;
`endif
  assign rise = irq_src & ~irq_d;
  assign elig = pending & ~mask;
  assign cur = NUM_IRQ'(1) << irq_vec;
  assign take = state == REQ && cpu_ack;
  assign clr = take ? cur : '0;
  assign irq_out = state == REQ;
  intr_prio_sel #(.NUM_IRQ(NUM_IRQ), .VEC_W(VEC_W)) u_sel (
    .req(elig),
    .vec(win),
    .any_valid(any)
  );
  // edge latch, mask register and request/ack/eoi sequencing; a new edge beats a same-cycle ack clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      irq_vec <= '0;
      pending <= '0;
      in_service <= '0;
      mask <= NUM_IRQ'(MASK_RESET);
      irq_d <= '0;
    end else begin
      irq_d <= irq_src;
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;
      if (state == IDLE && any) begin
        state <= REQ;
        irq_vec <= win;
      end else if (take) begin
        state <= SERVICE;
        in_service <= cur;
      end else if (state == REQ && !elig[irq_vec]) begin
        state <= IDLE;
      end else if (state == SERVICE && cpu_eoi) begin
        state <= IDLE;
        in_service <= '0;
      end else if (state != IDLE && state != REQ && state != SERVICE) begin
        state <= IDLE;
      end
    end
  end
endmodule
